// File: rtl/alu_framer_pkg.sv
// Shared definitions for the framed ALU command engine: FSM encoding,
// default marker/status bytes, frame length and a saturating counter helper.
package alu_framer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OPC,
        S_A,
        S_B,
        S_CHK,
        S_EXEC,
        S_CAPT,
        S_SEND_RES,
        S_SEND_STAT
    } state_t;

    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    // header, opcode, A, B, checksum
    localparam int FRAME_LEN = 5;

    // Error counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_cmd_framer.sv
// Framed command/response engine between the UART FIFOs and the ALU.
// Assembles header/opcode/A/B/checksum frames from the RX FIFO, runs the ALU
// on good frames and answers with result+ACK, or a lone NAK on bad frames.
// Optional inter-byte timeout is built when ALU_FRAMER_TIMEOUT_EN is defined.
module alu_cmd_framer
    import alu_framer_pkg::*;
#(
    parameter int                   DATA_BITS      = 8,
    parameter int                   OPCODE_BITS    = 6,
    parameter logic [DATA_BITS-1:0] HDR_BYTE       = DATA_BITS'(HDR_BYTE_DEF),
    parameter logic [DATA_BITS-1:0] ACK_BYTE       = DATA_BITS'(ACK_BYTE_DEF),
    parameter logic [DATA_BITS-1:0] NAK_BYTE       = DATA_BITS'(NAK_BYTE_DEF),
    parameter logic [15:0]          TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_empty,
    input  logic [DATA_BITS-1:0]   i_r_data,
    output logic                   o_rd_uart,
    input  logic                   i_tx_full,
    output logic [DATA_BITS-1:0]   o_w_data,
    output logic                   o_wr_uart,
    output logic [DATA_BITS-1:0]   o_op_a,
    output logic [DATA_BITS-1:0]   o_op_b,
    output logic [OPCODE_BITS-1:0] o_op_code,
    input  logic [DATA_BITS-1:0]   i_alu_result,
    output logic                   o_frame_ok,
    output logic [7:0]             o_err_count,
    output logic                   o_busy
);

    state_t                 state_reg, state_next;

    // Shadow registers hold the frame being received so the ALU operands
    // only move once the checksum has been verified.
    logic [DATA_BITS-1:0]   opc_reg, a_reg, b_reg, csum_reg;
    logic [DATA_BITS-1:0]   op_a_reg, op_b_reg;
    logic [OPCODE_BITS-1:0] op_code_reg;
    logic [DATA_BITS-1:0]   w_data_reg;
    logic                   frame_ok_reg;
    logic [7:0]             err_cnt_reg;

    logic                   rx_pop, tx_push, chk_bad, timeout_hit;

    assign rx_pop  = o_rd_uart;
    assign tx_push = o_wr_uart;

    // Opcodes wider than the ALU accepts are rejected like a checksum error.
    assign chk_bad = (i_r_data != csum_reg) || ((opc_reg >> OPCODE_BITS) != '0);

`ifdef ALU_FRAMER_TIMEOUT_EN
    logic [15:0] tmo_cnt_reg;
    logic        in_frame;

    assign in_frame    = state_reg inside {S_OPC, S_A, S_B, S_CHK};
    assign timeout_hit = in_frame && !rx_pop && (tmo_cnt_reg == TIMEOUT_CYCLES - 16'd1);

    // Inter-byte idle counter: restarts on every pop, counts only mid-frame.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt_reg <= 16'd0;
        end else if (!in_frame || rx_pop) begin
            tmo_cnt_reg <= 16'd0;
        end else if (!timeout_hit) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: RX states advance per popped byte, TX states per push.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (rx_pop && (i_r_data == HDR_BYTE)) state_next = S_OPC;
            S_OPC:       if (rx_pop) state_next = S_A;
            S_A:         if (rx_pop) state_next = S_B;
            S_B:         if (rx_pop) state_next = S_CHK;
            S_CHK:       if (rx_pop) state_next = chk_bad ? S_SEND_STAT : S_EXEC;
            S_EXEC:      state_next = S_CAPT;
            S_CAPT:      state_next = S_SEND_RES;
            S_SEND_RES:  if (tx_push) state_next = S_SEND_STAT;
            S_SEND_STAT: if (tx_push) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if (timeout_hit) state_next = S_SEND_STAT;
    end

    // FIFO strobes and busy flag, decoded from the current state.
    always_comb begin
        o_rd_uart = 1'b0;
        o_wr_uart = 1'b0;
        o_busy    = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE, S_OPC, S_A, S_B, S_CHK: o_rd_uart = !i_rx_empty;
            S_SEND_RES, S_SEND_STAT:        o_wr_uart = !i_tx_full;
            default: ;
        endcase
    end

    // Datapath: shadow capture, checksum, operand load, result/status byte.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            opc_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            csum_reg     <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_code_reg  <= '0;
            w_data_reg   <= '0;
            frame_ok_reg <= 1'b0;
            err_cnt_reg  <= 8'd0;
        end else begin
            frame_ok_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (rx_pop && (i_r_data == HDR_BYTE)) csum_reg <= '0;
                S_OPC: if (rx_pop) begin
                    opc_reg  <= i_r_data;
                    csum_reg <= csum_reg ^ i_r_data;
                end
                S_A: if (rx_pop) begin
                    a_reg    <= i_r_data;
                    csum_reg <= csum_reg ^ i_r_data;
                end
                S_B: if (rx_pop) begin
                    b_reg    <= i_r_data;
                    csum_reg <= csum_reg ^ i_r_data;
                end
                S_CHK: if (rx_pop && chk_bad) begin
                    err_cnt_reg <= sat_inc(err_cnt_reg);
                    w_data_reg  <= NAK_BYTE;
                end
                S_EXEC: begin
                    op_a_reg    <= a_reg;
                    op_b_reg    <= b_reg;
                    op_code_reg <= opc_reg[OPCODE_BITS-1:0];
                end
                S_CAPT: begin
                    w_data_reg   <= i_alu_result;
                    frame_ok_reg <= 1'b1;
                end
                S_SEND_RES: if (tx_push) w_data_reg <= ACK_BYTE;
                default: ;
            endcase
            if (timeout_hit) begin
                err_cnt_reg <= sat_inc(err_cnt_reg);
                w_data_reg  <= NAK_BYTE;
            end
        end
    end

    assign o_op_a      = op_a_reg;
    assign o_op_b      = op_b_reg;
    assign o_op_code   = op_code_reg;
    assign o_w_data    = w_data_reg;
    assign o_frame_ok  = frame_ok_reg;
    assign o_err_count = err_cnt_reg;

endmodule

// File: tb/tb_alu_cmd_framer.sv
// Self-checking bench for alu_cmd_framer: FWFT RX FIFO and TX log models,
// a small ALU model, a frame vector table plus cycle-exact corner sequences.
module tb_alu_cmd_framer;
    import alu_framer_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_empty;
    logic [7:0] i_r_data;
    logic       o_rd_uart;
    logic       i_tx_full;
    logic [7:0] o_w_data;
    logic       o_wr_uart;
    logic [7:0] o_op_a, o_op_b;
    logic [5:0] o_op_code;
    logic [7:0] i_alu_result;
    logic       o_frame_ok;
    logic [7:0] o_err_count;
    logic       o_busy;

    always #5 i_clk = ~i_clk;

    alu_cmd_framer #(.TIMEOUT_CYCLES(16'd100)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_empty(i_rx_empty), .i_r_data(i_r_data), .o_rd_uart(o_rd_uart),
        .i_tx_full(i_tx_full), .o_w_data(o_w_data), .o_wr_uart(o_wr_uart),
        .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_code(o_op_code),
        .i_alu_result(i_alu_result), .o_frame_ok(o_frame_ok),
        .o_err_count(o_err_count), .o_busy(o_busy)
    );

    // RX FIFO (first-word-fall-through) and TX capture log
    logic [7:0] rx_mem [256];
    logic [7:0] tx_mem [256];
    int rx_wr = 0, rx_rd = 0, tx_cnt = 0, ok_cnt = 0;
    logic tx_full = 1'b0;

    assign i_rx_empty = (rx_rd == rx_wr);
    assign i_r_data   = rx_mem[rx_rd[7:0]];
    assign i_tx_full  = tx_full;

    always @(posedge i_clk) begin
        if (o_rd_uart) rx_rd <= rx_rd + 1;
        if (o_wr_uart) begin
            tx_mem[tx_cnt[7:0]] <= o_w_data;
            tx_cnt <= tx_cnt + 1;
        end
        if (o_frame_ok) ok_cnt <= ok_cnt + 1;
    end

    // ALU model: 0x20 add, 0x22 subtract, everything else xor
    always_comb begin
        case (o_op_code)
            6'h20:   i_alu_result = o_op_a + o_op_b;
            6'h22:   i_alu_result = o_op_a - o_op_b;
            default: i_alu_result = o_op_a ^ o_op_b;
        endcase
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[rx_wr[7:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    function automatic logic [7:0] tx_at(input int idx);
        return tx_mem[idx[7:0]];
    endfunction

    // Wait (bounded) until the expected TX bytes are logged, RX drained and FSM idle.
    task automatic wait_done(input int tx_target, input int budget, input string name);
        int  n = 0;
        bit  done;
        done = (tx_cnt >= tx_target) && !o_busy && (rx_rd == rx_wr);
        while (!done && n < budget) begin
            @(negedge i_clk);
            n++;
            done = (tx_cnt >= tx_target) && !o_busy && (rx_rd == rx_wr);
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [55:0] bytes;   // first byte in the top octet
        int          nb;
        int          ntx;
        logic [7:0]  tx0, tx1;
        int          err;
        logic [7:0]  a, b;
        logic [5:0]  op;
        int          ok;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int tx0, rd0, ok0;

        vecs[0] = '{56'hA5_20_05_03_26_00_00, 5, 2, 8'h08, 8'h06, 0, 8'h05, 8'h03, 6'h20, 1};
        vecs[1] = '{56'hA5_20_05_03_27_00_00, 5, 1, 8'h15, 8'h00, 1, 8'h05, 8'h03, 6'h20, 0};
        vecs[2] = '{56'h00_FF_A5_22_0A_02_2A, 7, 2, 8'h08, 8'h06, 1, 8'h0A, 8'h02, 6'h22, 1};
        vecs[3] = '{56'hA5_C1_01_02_C2_00_00, 5, 1, 8'h15, 8'h00, 2, 8'h0A, 8'h02, 6'h22, 0};
        vecs[4] = '{56'hA5_21_FF_01_DF_00_00, 5, 2, 8'hFE, 8'h06, 2, 8'hFF, 8'h01, 6'h21, 1};
        vecs[5] = '{56'hA5_20_A5_A5_20_00_00, 5, 2, 8'h4A, 8'h06, 2, 8'hA5, 8'hA5, 6'h20, 1};

        // Reset values
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_op_a", 32'(o_op_a), 0);
        check("rst_op_b", 32'(o_op_b), 0);
        check("rst_op_code", 32'(o_op_code), 0);
        check("rst_err", 32'(o_err_count), 0);
        check("rst_frame_ok", 32'(o_frame_ok), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_rd", 32'(o_rd_uart), 0);
        check("rst_wr", 32'(o_wr_uart), 0);
        check("rst_w_data", 32'(o_w_data), 0);
        i_reset = 1'b1;
        @(negedge i_clk);

        // Cycle-exact good frame: t = edge accepting the checksum byte
        tx0 = tx_cnt; rd0 = rx_rd; ok0 = ok_cnt;
        push_byte(8'hA5); push_byte(8'h20); push_byte(8'h05); push_byte(8'h03); push_byte(8'h26);
        repeat (FRAME_LEN) @(negedge i_clk);
        check("t_pops", 32'(rx_rd - rd0), 5);
        check("t_op_a_before", 32'(o_op_a), 0);
        check("t_busy", 32'(o_busy), 1);
        @(negedge i_clk);
        check("t1_op_a", 32'(o_op_a), 32'h05);
        check("t1_op_b", 32'(o_op_b), 32'h03);
        check("t1_op_code", 32'(o_op_code), 32'h20);
        check("t1_frame_ok", 32'(o_frame_ok), 0);
        @(negedge i_clk);
        check("t2_frame_ok", 32'(o_frame_ok), 1);
        check("t2_w_data", 32'(o_w_data), 32'h08);
        check("t2_wr", 32'(o_wr_uart), 1);
        @(negedge i_clk);
        check("t3_frame_ok", 32'(o_frame_ok), 0);
        check("t3_w_data", 32'(o_w_data), 32'h06);
        check("t3_tx_cnt", 32'(tx_cnt - tx0), 1);
        @(negedge i_clk);
        check("t4_busy", 32'(o_busy), 0);
        check("t4_tx_cnt", 32'(tx_cnt - tx0), 2);
        check("t4_tx0", 32'(tx_at(tx0)), 32'h08);
        check("t4_tx1", 32'(tx_at(tx0 + 1)), 32'h06);
        check("t4_ok", 32'(ok_cnt - ok0), 1);

        // Table of frames
        for (int i = 0; i < 6; i++) begin
            tx0 = tx_cnt; rd0 = rx_rd; ok0 = ok_cnt;
            for (int k = 0; k < vecs[i].nb; k++)
                push_byte(vecs[i].bytes[55 - 8*k -: 8]);
            wait_done(tx0 + vecs[i].ntx, 100, $sformatf("v%0d", i));
            check($sformatf("v%0d_ntx", i), 32'(tx_cnt - tx0), 32'(vecs[i].ntx));
            check($sformatf("v%0d_tx0", i), 32'(tx_at(tx0)), 32'(vecs[i].tx0));
            if (vecs[i].ntx == 2)
                check($sformatf("v%0d_tx1", i), 32'(tx_at(tx0 + 1)), 32'(vecs[i].tx1));
            check($sformatf("v%0d_err", i), 32'(o_err_count), 32'(vecs[i].err));
            check($sformatf("v%0d_op_a", i), 32'(o_op_a), 32'(vecs[i].a));
            check($sformatf("v%0d_op_b", i), 32'(o_op_b), 32'(vecs[i].b));
            check($sformatf("v%0d_op_code", i), 32'(o_op_code), 32'(vecs[i].op));
            check($sformatf("v%0d_pops", i), 32'(rx_rd - rd0), 32'(vecs[i].nb));
            check($sformatf("v%0d_ok", i), 32'(ok_cnt - ok0), 32'(vecs[i].ok));
            $display("vector %0d: tx=%0d bytes err=%0d op=%0h a=%0h b=%0h", i,
                     tx_cnt - tx0, o_err_count, o_op_code, o_op_a, o_op_b);
        end

        // TX full stall during result send
        tx_full = 1'b1;
        tx0 = tx_cnt;
        push_byte(8'hA5); push_byte(8'h20); push_byte(8'h01); push_byte(8'h02); push_byte(8'h23);
        repeat (7) @(negedge i_clk);
        check("stall_busy", 32'(o_busy), 1);
        for (int c = 0; c < 20; c++) begin
            check("stall_wr", 32'(o_wr_uart), 0);
            check("stall_w_data", 32'(o_w_data), 32'h03);
            @(negedge i_clk);
        end
        check("stall_tx_cnt", 32'(tx_cnt - tx0), 0);
        tx_full = 1'b0;
        #1;
        check("stall_release_wr", 32'(o_wr_uart), 1);
        @(negedge i_clk);
        check("stall_tx0", 32'(tx_at(tx0)), 32'h03);
        check("stall_ack_w_data", 32'(o_w_data), 32'h06);
        @(negedge i_clk);
        check("stall_tx_total", 32'(tx_cnt - tx0), 2);
        check("stall_tx1", 32'(tx_at(tx0 + 1)), 32'h06);
        check("stall_idle", 32'(o_busy), 0);

        // Reset mid-frame after byte A
        tx0 = tx_cnt;
        push_byte(8'hA5); push_byte(8'h20); push_byte(8'h07);
        repeat (3) @(negedge i_clk);
        check("mid_busy", 32'(o_busy), 1);
        i_reset = 1'b0;
        #1;
        check("mid_rst_op_a", 32'(o_op_a), 0);
        check("mid_rst_op_b", 32'(o_op_b), 0);
        check("mid_rst_op_code", 32'(o_op_code), 0);
        check("mid_rst_err", 32'(o_err_count), 0);
        check("mid_rst_w_data", 32'(o_w_data), 0);
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_wr", 32'(o_wr_uart), 0);
        check("mid_rst_frame_ok", 32'(o_frame_ok), 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        push_byte(8'hA5); push_byte(8'h20); push_byte(8'h04); push_byte(8'h04); push_byte(8'h20);
        wait_done(tx0 + 2, 100, "after_rst");
        check("after_rst_ntx", 32'(tx_cnt - tx0), 2);
        check("after_rst_tx0", 32'(tx_at(tx0)), 32'h08);
        check("after_rst_tx1", 32'(tx_at(tx0 + 1)), 32'h06);
        check("after_rst_op_a", 32'(o_op_a), 32'h04);
        check("after_rst_err", 32'(o_err_count), 0);
        $display("reset mid-frame: tx=%0d bytes op_a=%0h err=%0d", tx_cnt - tx0, o_op_a, o_err_count);

`ifdef ALU_FRAMER_TIMEOUT_EN
        // Truncated frame times out into a NAK
        tx0 = tx_cnt;
        push_byte(8'hA5); push_byte(8'h20);
        repeat (50) @(negedge i_clk);
        check("tmo_early", 32'(tx_cnt - tx0), 0);
        wait_done(tx0 + 1, 300, "tmo");
        check("tmo_ntx", 32'(tx_cnt - tx0), 1);
        check("tmo_nak", 32'(tx_at(tx0)), 32'h15);
        check("tmo_err", 32'(o_err_count), 1);
        $display("timeout: tx=%0h err=%0d", tx_at(tx0), o_err_count);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_framer.md
Name: alu_cmd_framer

Overview:
Framed command/response engine between the UART FIFOs and the ALU, replacing the unframed byte-triplet interface. It pops bytes from the RX FIFO and assembles 5-byte frames: header, opcode, A, B, checksum. On a valid frame it drives the ALU operands, captures the result and pushes a 2-byte response (result, status) into the TX FIFO. On an invalid frame it pushes a single NAK byte.

Parameters:
DATA_BITS, 8, data byte, operand and result width
OPCODE_BITS, 6, ALU opcode width; must be at most DATA_BITS
HDR_BYTE, 8'hA5, frame start marker
ACK_BYTE, 8'h06, status byte sent after a valid result
NAK_BYTE, 8'h15, status byte sent for a bad frame
TIMEOUT_CYCLES, 16'd50000, inter-byte timeout; used only with the optional feature

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-low reset
i_rx_empty  in  1  RX FIFO empty; i_r_data is valid whenever this is low (first-word-fall-through)
i_r_data  in  DATA_BITS  RX FIFO head byte
o_rd_uart  out  1  RX pop strobe, one cycle per byte
i_tx_full  in  1  TX FIFO full
o_w_data  out  DATA_BITS  TX byte
o_wr_uart  out  1  TX push strobe, one cycle per byte
o_op_a  out  DATA_BITS  ALU operand A
o_op_b  out  DATA_BITS  ALU operand B
o_op_code  out  OPCODE_BITS  ALU opcode
i_alu_result  in  DATA_BITS  combinational ALU result
o_frame_ok  out  1  one-cycle pulse when a valid frame is executed
o_err_count  out  8  count of bad frames, saturates at 255
o_busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset (i_reset=0, asynchronous): state S_IDLE.
  - Reset values: o_op_a=0, o_op_b=0, o_op_code=0, o_err_count=0, o_frame_ok=0, o_busy=0, o_rd_uart=0, o_wr_uart=0, o_w_data=0.
  - Shadow registers and checksum accumulator cleared.
  - Reset mid-frame abandons the frame; no response is sent.
- FSM states: S_IDLE, S_OPC, S_A, S_B, S_CHK, S_EXEC, S_CAPT, S_SEND_RES, S_SEND_STAT.
- RX handshake: in S_IDLE through S_CHK, o_rd_uart = !i_rx_empty (combinational). The byte on i_r_data is consumed at that same clock edge. At most one byte is taken per cycle.
- S_IDLE:
  - A byte equal to HDR_BYTE moves to S_OPC and clears the checksum.
  - Any other byte is popped and discarded. The error count is unchanged.
- S_OPC, S_A, S_B: latch the byte into its shadow register and XOR it into the checksum, then advance.
- S_CHK, received byte compared with the accumulated checksum:
  - Bad frame (mismatch, or opcode bits [DATA_BITS-1:OPCODE_BITS] nonzero): o_err_count +1 (saturating), o_w_data=NAK_BYTE, go to S_SEND_STAT.
  - Good frame: go to S_EXEC.
- Operand outputs change only on a good frame; a bad frame leaves them unchanged.
- Good-frame timing, where t is the edge that accepts the checksum byte:
  - S_EXEC: at edge t+1, o_op_a/o_op_b/o_op_code load from the shadow registers.
  - S_CAPT: at edge t+2, i_alu_result registers into o_w_data and o_frame_ok pulses high for one cycle.
  - Next state is S_SEND_RES.
- TX handshake: in S_SEND_RES and S_SEND_STAT, o_wr_uart = !i_tx_full (combinational). The state advances only on the edge where o_wr_uart=1.
  - While i_tx_full=1 the FSM stalls with o_w_data held stable.
  - S_SEND_RES → S_SEND_STAT, with o_w_data=ACK_BYTE.
  - S_SEND_STAT → S_IDLE.
- RX bytes arriving during S_EXEC through S_SEND_STAT stay in the FIFO and are not popped.
- Back-to-back frames are supported. The earliest header pop for the next frame is the cycle after the S_SEND_STAT push.
- A header-valued byte in any data position is treated as data; there is no re-sync within a frame.

Optional Feature:
- Macro ALU_FRAMER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every pop and increments in S_OPC through S_CHK while no byte is popped.
  - Reaching TIMEOUT_CYCLES-1 abandons the frame: o_err_count +1 (saturating), NAK queued, go to S_SEND_STAT.
- Undefined: no counter is built; the FSM waits indefinitely between bytes.

Decomposition:
- Package alu_framer_pkg holds:
  - the state enum encoding
  - HDR/ACK/NAK default constants
  - the 5-byte frame length constant
- No sub-module: the FSM and datapath form a single module.
- The timeout counter is inline, wrapped by the macro.

Test Plan:
1. Frame A5,20,05,03,26 with the ALU modelled as ADD (opcode 0x20) → pops 5 bytes; o_op_a=05, o_op_b=03, o_op_code=20 at t+1; o_frame_ok pulse at t+2; TX receives 08 then 06.
2. Frame A5,20,05,03,27 (bad checksum) → TX receives 15 only; o_err_count=1; operand outputs unchanged.
3. Bytes 00,FF,A5,22,0A,02,2A → first two bytes discarded with no error; opcode 22 executed and ACK sent.
4. i_tx_full held high for 20 cycles during S_SEND_RES → no push, o_w_data stable; result pushed on the first non-full cycle.
5. i_reset pulsed low after byte A → all outputs return to their reset values; a following complete frame executes normally.
6. With ALU_FRAMER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send A5,20 then idle 100 cycles → NAK pushed, o_err_count=1, FSM returns to S_IDLE.
